// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
// Purpose: Tuse/Tnew encodings, HI/LO operation codes, sequencer state codes and the
//          exception vector shared with the pipeline registers and the PC.
// Ports:   none (package)
package pipe_hazard_ctrl_pkg;

  // Tuse of 3 means the operand is never read, so it can never be younger than any Tnew.
  localparam logic [1:0] TUSE_NONE  = 2'd3;
  localparam logic [1:0] TNEW_READY = 2'd0;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_EXC   = 2'b10
  } hz_state_e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - stage hazard inputs and pipeline control outputs
// Purpose: groups the D/E/M stage hazard information and the hold/bubble/flush controls.
// Ports:   slave  - hazard controller side (stage info in, controls out)
//          master - pipeline side (stage info out, controls in)
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        D_rs;
  logic [4:0]        D_rt;
  logic [1:0]        D_tuse_rs;
  logic [1:0]        D_tuse_rt;
  logic              D_is_md;
  logic              D_is_eret;
  logic [4:0]        E_A3;
  logic [4:0]        M_A3;
  logic [1:0]        E_tnew;
  logic [1:0]        M_tnew;
  logic [1:0]        E_md_start;
  logic              E_mtc0_epc;
  logic              M_mtc0_epc;
  logic              exc_req;
  logic              stall_FD;
  logic              bubble_E;
  logic              flush_req;
  logic              md_busy;
  logic [1:0]        state;
  logic [PERF_W-1:0] stall_cnt;

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, D_is_eret,
    input  E_A3, M_A3, E_tnew, M_tnew, E_md_start, E_mtc0_epc, M_mtc0_epc, exc_req,
    output stall_FD, bubble_E, flush_req, md_busy, state, stall_cnt
  );

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, D_is_eret,
    output E_A3, M_A3, E_tnew, M_tnew, E_md_start, E_mtc0_epc, M_mtc0_epc, exc_req,
    input  stall_FD, bubble_E, flush_req, md_busy, state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// rtl/pipe_hazard_ctrl_md_busy_timer.sv - HI/LO busy timer
// Purpose: loads the mult/div latency when an operation issues from E and counts down.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          start_i     - E-stage HI/LO operation code (11 behaves as none)
//          kill_i      - issuing instruction is being flushed; its start is dropped
//          md_busy_o   - counter nonzero
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] start_i,
  input  logic       kill_i,
  output logic       md_busy_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!kill_i && start_i == MD_MULT) begin
      count_d = CNT_W'(MULT_LAT);
    end else if (!kill_i && start_i == MD_DIV) begin
      count_d = CNT_W'(DIV_LAT);
    end else if (count_q != '0) begin
      // A count already running keeps going through a flush.
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign md_busy_o = (count_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hold/bubble/flush sequencer
// Purpose: per cycle decides whether PC/IF_ID hold, ID_EX takes a bubble, or every pipeline
//          register flushes to the exception vector; owns the HI/LO busy timer and the
//          RUN/STALL/EXC state machine; counts stalled cycles.
// Ports:   clk   - pipeline clock
//          reset - asynchronous active-low reset
//          hz    - stage hazard inputs, stall_FD/bubble_E/flush_req/md_busy/state/stall_cnt
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic              md_busy;
  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              stall_eret;
  logic              stall_any;
  logic              flush;
  logic              stall;
  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (hz.E_md_start),
    .kill_i    (hz.exc_req),
    .md_busy_o (md_busy)
  );

  always_comb begin
    stall_rs   = (hz.D_rs != 5'd0) &&
                 ((hz.D_rs == hz.E_A3 && hz.D_tuse_rs < hz.E_tnew) ||
                  (hz.D_rs == hz.M_A3 && hz.D_tuse_rs < hz.M_tnew));
    stall_rt   = (hz.D_rt != 5'd0) &&
                 ((hz.D_rt == hz.E_A3 && hz.D_tuse_rt < hz.E_tnew) ||
                  (hz.D_rt == hz.M_A3 && hz.D_tuse_rt < hz.M_tnew));
    stall_md   = hz.D_is_md && (md_busy || hz.E_md_start != MD_NONE);
    // eret reads EPC in D; an mtc0 to EPC still in E or M has not written it yet.
    stall_eret = hz.D_is_eret && (hz.E_mtc0_epc || hz.M_mtc0_epc);
    stall_any  = stall_rs || stall_rt || stall_md || stall_eret;
    // Controls stay quiet while reset is held; the exception flush overrides any hold.
    flush      = reset && hz.exc_req;
    stall      = reset && stall_any && !flush;
  end

  always_comb begin
    state_d = state_q;
    if (hz.exc_req) begin
      state_d = ST_EXC;
    end else begin
      case (state_q)
        ST_RUN:   state_d = stall ? ST_STALL : ST_RUN;
        ST_STALL: state_d = stall ? ST_STALL : ST_RUN;
        ST_EXC:   state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {PERF_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_FD  = stall;
  assign hz.bubble_E  = stall;
  assign hz.flush_req = flush;
  assign hz.md_busy   = md_busy;
  assign hz.state     = state_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  int   busy_seen;

  pipe_hazard_ctrl_if #(.PERF_W(32)) hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.D_rs = 5'd0; hz.D_rt = 5'd0; hz.D_tuse_rs = 2'd3; hz.D_tuse_rt = 2'd3;
    hz.D_is_md = 1'b0; hz.D_is_eret = 1'b0;
    hz.E_A3 = 5'd0; hz.M_A3 = 5'd0; hz.E_tnew = 2'd0; hz.M_tnew = 2'd0;
    hz.E_md_start = 2'b00; hz.E_mtc0_epc = 1'b0; hz.M_mtc0_epc = 1'b0; hz.exc_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    clear_inputs();
    #12;
    chk("rst_state", 32'(hz.state), 32'd0);
    chk("rst_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_cnt", hz.stall_cnt, 32'd0);
    chk("rst_stall", 32'(hz.stall_FD), 32'd0);
    chk("rst_flush", 32'(hz.flush_req), 32'd0);
    reset = 1'b1;
    cyc();

    // 1: lw $1 in E, addu in D reads $1 at Tuse 1
    hz.E_A3 = 5'd1; hz.E_tnew = 2'd2; hz.D_rs = 5'd1; hz.D_tuse_rs = 2'd1;
    #1;
    chk("t1_stall", 32'(hz.stall_FD), 32'd1);
    chk("t1_bubble", 32'(hz.bubble_E), 32'd1);
    chk("t1_state_run", 32'(hz.state), 32'd0);
    cyc();
    hz.E_A3 = 5'd0; hz.E_tnew = 2'd0; hz.M_A3 = 5'd1; hz.M_tnew = 2'd1;
    #1;
    chk("t1_state_stall", 32'(hz.state), 32'd1);
    chk("t1_cnt", hz.stall_cnt, 32'd1);
    chk("t1_released", 32'(hz.stall_FD), 32'd0);
    cyc();
    chk("t1_state_back", 32'(hz.state), 32'd0);

    // 2: register 0 never stalls; rt path stalls against M
    clear_inputs();
    hz.E_A3 = 5'd0; hz.D_rs = 5'd0; hz.E_tnew = 2'd2; hz.D_tuse_rs = 2'd0;
    #1;
    chk("t2_r0_nostall", 32'(hz.stall_FD), 32'd0);
    cyc();
    chk("t2_cnt_same", hz.stall_cnt, 32'd1);
    clear_inputs();
    hz.D_rt = 5'd7; hz.M_A3 = 5'd7; hz.M_tnew = 2'd2; hz.D_tuse_rt = 2'd1;
    #1;
    chk("t2_rt_stall", 32'(hz.stall_FD), 32'd1);
    cyc();
    clear_inputs();
    #1;
    chk("t2_cnt_rt", hz.stall_cnt, 32'd2);
    cyc();

    // E_md_start=11 does not start the timer
    hz.E_md_start = 2'b11;
    cyc();
    hz.E_md_start = 2'b00;
    #1;
    chk("t2_md11_idle", 32'(hz.md_busy), 32'd0);

    // 3: div issues from E while mfhi waits in D
    hz.E_md_start = 2'b10; hz.D_is_md = 1'b1;
    #1;
    chk("t3_issue_stall", 32'(hz.stall_FD), 32'd1);
    chk("t3_issue_busy", 32'(hz.md_busy), 32'd0);
    cyc();
    hz.E_md_start = 2'b00;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (hz.md_busy === 1'b1 && hz.stall_FD === 1'b1) busy_seen++;
      cyc();
    end
    chk("t3_busy_cycles", 32'(busy_seen), 32'd10);
    chk("t3_busy_done", 32'(hz.md_busy), 32'd0);
    chk("t3_stall_done", 32'(hz.stall_FD), 32'd0);
    chk("t3_cnt", hz.stall_cnt, 32'd13);
    hz.D_is_md = 1'b0;
    cyc();
    chk("t3_state", 32'(hz.state), 32'd0);

    // 4: exception during a stall kills a mult issuing the same cycle
    hz.E_A3 = 5'd3; hz.E_tnew = 2'd2; hz.D_rs = 5'd3; hz.D_tuse_rs = 2'd0;
    hz.E_md_start = 2'b01; hz.exc_req = 1'b1;
    #1;
    chk("t4_flush", 32'(hz.flush_req), 32'd1);
    chk("t4_stall_masked", 32'(hz.stall_FD), 32'd0);
    chk("t4_bubble_masked", 32'(hz.bubble_E), 32'd0);
    cyc();
    hz.exc_req = 1'b0; hz.E_md_start = 2'b00;
    #1;
    chk("t4_state_exc", 32'(hz.state), 32'd2);
    chk("t4_busy_killed", 32'(hz.md_busy), 32'd0);
    chk("t4_stall_in_exc", 32'(hz.stall_FD), 32'd1);
    chk("t4_flush_gone", 32'(hz.flush_req), 32'd0);
    cyc();
    chk("t4_state_run", 32'(hz.state), 32'd0);
    chk("t4_cnt", hz.stall_cnt, 32'd14);
    clear_inputs();
    cyc();

    // running mult count survives a flush
    hz.E_md_start = 2'b01;
    cyc();
    hz.E_md_start = 2'b00; hz.exc_req = 1'b1;
    cyc();
    hz.exc_req = 1'b0;
    #1;
    chk("t4_busy_through_flush", 32'(hz.md_busy), 32'd1);
    cyc(); cyc(); cyc();
    chk("t4_busy_last", 32'(hz.md_busy), 32'd1);
    cyc();
    chk("t4_busy_end", 32'(hz.md_busy), 32'd0);
    chk("t4_cnt_same", hz.stall_cnt, 32'd14);

    // 5: eret behind mtc0 EPC
    hz.D_is_eret = 1'b1; hz.M_mtc0_epc = 1'b1;
    #1;
    chk("t5_m_stall", 32'(hz.stall_FD), 32'd1);
    cyc();
    hz.M_mtc0_epc = 1'b0;
    #1;
    chk("t5_m_release", 32'(hz.stall_FD), 32'd0);
    cyc();
    hz.E_mtc0_epc = 1'b1;
    #1;
    chk("t5_e_stall", 32'(hz.stall_FD), 32'd1);
    cyc();
    hz.E_mtc0_epc = 1'b0; hz.M_mtc0_epc = 1'b1;
    #1;
    chk("t5_em_stall", 32'(hz.stall_FD), 32'd1);
    cyc();
    hz.M_mtc0_epc = 1'b0;
    #1;
    chk("t5_e_release", 32'(hz.stall_FD), 32'd0);
    chk("t5_cnt", hz.stall_cnt, 32'd17);
    clear_inputs();
    cyc();

    // 6: asynchronous reset mid-divide (counter at 6)
    hz.E_md_start = 2'b10; hz.D_is_md = 1'b1;
    cyc();
    hz.E_md_start = 2'b00;
    cyc(); cyc(); cyc(); cyc();
    chk("t6_busy_pre", 32'(hz.md_busy), 32'd1);
    chk("t6_state_pre", 32'(hz.state), 32'd1);
    chk("t6_cnt_pre", hz.stall_cnt, 32'd22);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy_async", 32'(hz.md_busy), 32'd0);
    chk("t6_state_async", 32'(hz.state), 32'd0);
    chk("t6_cnt_async", hz.stall_cnt, 32'd0);
    chk("t6_stall_async", 32'(hz.stall_FD), 32'd0);
    cyc();
    chk("t6_cnt_held", hz.stall_cnt, 32'd0);
    clear_inputs();
    reset = 1'b1;
    cyc();
    chk("t6_state_after", 32'(hz.state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
